// File: rtl/reg_dump.sv
// ============================================================================
//  Module      : reg_dump
//  Description : Debug readout engine for the picoMIPS register file. A start
//                pulse walks register addresses 0..NUM_REGS-1 on the second
//                read port, captures each value and sends a 0xA5 header byte
//                followed by one byte per register on an 8N1 UART line.
//  Ports       : clk      - system clock, rising edge
//                reset    - synchronous active-high reset
//                start    - dump request, honoured only when idle
//                rd_addr  - register-file read address (to Rs)
//                rd_data  - register-file read data, combinational
//                busy     - high while a frame is on the line
//                done     - one-cycle pulse after the final stop bit
//                tx       - UART serial output, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump #(
    parameter int n            = 8,
    parameter int NUM_REGS     = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [2:0]   rd_addr,
    input  logic [n-1:0] rd_data,
    output logic         busy,
    output logic         done,
    output logic         tx
);

    localparam int              c_BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      c_LAST_IDX  = 4'(NUM_REGS);
    localparam logic [7:0]      c_HEADER    = 8'hA5;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_FETCH = 3'd4;

    logic [2:0]      r_state,   w_state;
    logic [7:0]      r_shift,   w_shift;
    logic [3:0]      r_idx,     w_idx;
    logic [2:0]      r_bitcnt,  w_bitcnt;
    logic [c_BW-1:0] r_baud,    w_baud;
    logic [2:0]      r_rd_addr, w_rd_addr;
    logic            r_tx,      w_tx;
    logic            r_busy,    w_busy;
    logic            r_done,    w_done;
    logic            w_baud_end;

    assign rd_addr = r_rd_addr;
    assign busy    = r_busy;
    assign done    = r_done;
    assign tx      = r_tx;

    // tx is registered, so every transition loads the line level of the
    // state being entered; it then holds for the whole bit period.
    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_idx      = r_idx;
        w_bitcnt   = r_bitcnt;
        w_baud     = r_baud;
        w_rd_addr  = r_rd_addr;
        w_tx       = r_tx;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_baud_end = (r_baud == c_BAUD_LAST);

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state   = c_ST_START;
                    w_shift   = c_HEADER;
                    w_idx     = 4'd0;
                    w_rd_addr = 3'd0;
                    w_baud    = '0;
                    w_tx      = 1'b0;
                    w_busy    = 1'b1;
                end
            end

            c_ST_START: begin
                if (w_baud_end) begin
                    w_state  = c_ST_DATA;
                    w_baud   = '0;
                    w_bitcnt = 3'd0;
                    w_tx     = r_shift[0];
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end

            c_ST_DATA: begin
                if (w_baud_end) begin
                    w_baud  = '0;
                    w_shift = {1'b0, r_shift[7:1]};
                    if (r_bitcnt == 3'd7) begin
                        w_state = c_ST_STOP;
                        w_tx    = 1'b1;
                    end else begin
                        w_bitcnt = r_bitcnt + 3'd1;
                        // Next bit is the one about to shift into position 0.
                        w_tx     = r_shift[1];
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end

            c_ST_STOP: begin
                if (w_baud_end) begin
                    w_baud = '0;
                    if (r_idx == c_LAST_IDX) begin
                        w_state = c_ST_IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end else begin
                        w_state = c_ST_FETCH;
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end

            c_ST_FETCH: begin
                // rd_addr already equals idx here and has been stable for a
                // full byte time, so rd_data is settled.
                w_shift   = rd_data[7:0];
                w_rd_addr = r_idx[2:0] + 3'd1;
                w_idx     = r_idx + 4'd1;
                w_state   = c_ST_START;
                w_baud    = '0;
                w_tx      = 1'b0;
            end

            default: begin
                w_state = c_ST_IDLE;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_shift   <= 8'h00;
            r_idx     <= 4'd0;
            r_bitcnt  <= 3'd0;
            r_baud    <= '0;
            r_rd_addr <= 3'd0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_idx     <= w_idx;
            r_bitcnt  <= w_bitcnt;
            r_baud    <= w_baud;
            r_rd_addr <= w_rd_addr;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

endmodule

`default_nettype wire
